// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA/ROR shifter with valid/ready handshake and a tag carried alongside each beat.
// Optional SHIFTER_WORD32_EN adds in_word for 32-bit operations sign-extended to the full width.
module pipelined_shifter #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amount,
  input  logic [1:0]               in_op,
  input  logic [TAG_WIDTH-1:0]     in_tag,
`ifdef SHIFTER_WORD32_EN
  input  logic                     in_word,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_WIDTH-1:0]     out_tag
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int P     = PIPE_STAGES;

  function automatic int slice_of(input int j);
    return (j * P) / LOG2W;
  endfunction

  // One mux level: shift/rotate by s, SRA filling from the stored operand sign.
  function automatic logic [WIDTH-1:0] shift_full(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] op,
                                                   input logic sign, input int s);
    logic signed [WIDTH:0] ext;
    logic [WIDTH-1:0]      r;
    ext = $signed({sign, d}) >>> s;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = ext[WIDTH-1:0];
      default: r = (d >> s) | (d << (WIDTH - s));
    endcase
    return r;
  endfunction

`ifdef SHIFTER_WORD32_EN
  function automatic logic [31:0] shift_word(input logic [31:0] d, input logic [1:0] op,
                                             input logic sign, input int s);
    logic signed [32:0] ext;
    logic [31:0]        r;
    ext = $signed({sign, d}) >>> s;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = ext[31:0];
      default: r = (d >> s) | (d << (32 - s));
    endcase
    return r;
  endfunction
`endif

  logic [P-1:0]           vld_p;
  logic [WIDTH-1:0]       data_p [P];
  logic [LOG2W-1:0]       amt_p  [P];
  logic [1:0]             op_p   [P];
  logic [P-1:0]           sign_p;
  logic [TAG_WIDTH-1:0]   tag_p  [P];
`ifdef SHIFTER_WORD32_EN
  logic [P-1:0]           word_p;
  logic [P-1:0]           src_word;
`endif

  logic [WIDTH-1:0]       src_data [P];
  logic [LOG2W-1:0]       src_amt  [P];
  logic [1:0]             src_op   [P];
  logic [P-1:0]           src_sign;
  logic [TAG_WIDTH-1:0]   src_tag  [P];
  logic [WIDTH-1:0]       nxt_data [P];

  logic [P-1:0]           adv;
  logic [P-1:0]           free;
  logic [P-1:0]           ld;

  // Advance chain runs from the output back to the input; a slice is free when
  // it is empty or its beat moves on this cycle.
  always_comb begin
    logic down_ok;
    adv     = '0;
    free    = '0;
    ld      = '0;
    down_ok = out_ready;
    for (int k = P - 1; k >= 0; k--) begin
      adv[k]  = vld_p[k] && down_ok;
      down_ok = !vld_p[k] || down_ok;
      free[k] = down_ok;
    end
    in_ready = free[0];
    ld[0]    = in_valid && free[0];
    for (int k = 1; k < P; k++) ld[k] = adv[k-1];
  end

  always_comb begin
    logic [WIDTH-1:0] d;
    src_data[0] = in_data;
    src_amt[0]  = in_amount;
    src_op[0]   = in_op;
    src_sign    = '0;
    src_sign[0] = in_data[WIDTH-1];
    src_tag[0]  = in_tag;
`ifdef SHIFTER_WORD32_EN
    src_word    = '0;
    src_word[0] = in_word;
    if (in_word) begin
      src_sign[0] = in_data[31];
      for (int i = 5; i < LOG2W; i++) src_amt[0][i] = 1'b0;
    end
`endif
    for (int k = 1; k < P; k++) begin
      src_data[k] = data_p[k-1];
      src_amt[k]  = amt_p[k-1];
      src_op[k]   = op_p[k-1];
      src_sign[k] = sign_p[k-1];
      src_tag[k]  = tag_p[k-1];
`ifdef SHIFTER_WORD32_EN
      src_word[k] = word_p[k-1];
`endif
    end
    for (int k = 0; k < P; k++) begin
      d = src_data[k];
      for (int j = 0; j < LOG2W; j++) begin
        if (slice_of(j) == k && src_amt[k][j]) begin
`ifdef SHIFTER_WORD32_EN
          if (src_word[k]) d[31:0] = shift_word(d[31:0], src_op[k], src_sign[k], 1 << j);
          else             d       = shift_full(d, src_op[k], src_sign[k], 1 << j);
`else
          d = shift_full(d, src_op[k], src_sign[k], 1 << j);
`endif
        end
      end
`ifdef SHIFTER_WORD32_EN
      if (k == P - 1 && src_word[k]) d = WIDTH'($signed(d[31:0]));
`endif
      nxt_data[k] = d;
    end
  end

  // Slice boundary: valid bits are the only reset state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
    end else begin
      for (int k = 0; k < P; k++)
        if (free[k]) vld_p[k] <= ld[k];
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < P; k++) begin
      if (ld[k]) begin
        data_p[k] <= nxt_data[k];
        amt_p[k]  <= src_amt[k];
        op_p[k]   <= src_op[k];
        sign_p[k] <= src_sign[k];
        tag_p[k]  <= src_tag[k];
`ifdef SHIFTER_WORD32_EN
        word_p[k] <= src_word[k];
`endif
      end
    end
  end

  // Gating by the last valid bit forces data/tag to zero while in reset.
  assign out_valid = vld_p[P-1];
  assign out_data  = vld_p[P-1] ? data_p[P-1] : '0;
  assign out_tag   = vld_p[P-1] ? tag_p[P-1]  : '0;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter (WIDTH=32, PIPE_STAGES=2); 64-bit word-mode checks when SHIFTER_WORD32_EN is defined.
module tb_pipelined_shifter;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_amount = '0;
  logic [1:0]  in_op = '0;
  logic [4:0]  in_tag = '0;
  logic        in_word = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  pipelined_shifter #(.WIDTH(32), .PIPE_STAGES(2), .TAG_WIDTH(5)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amount(in_amount), .in_op(in_op), .in_tag(in_tag),
`ifdef SHIFTER_WORD32_EN
    .in_word(in_word),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

`ifdef SHIFTER_WORD32_EN
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [63:0] w_in_data = '0;
  logic [5:0]  w_in_amount = '0;
  logic [1:0]  w_in_op = '0;
  logic [4:0]  w_in_tag = '0;
  logic        w_in_word = 1'b0;
  logic        w_out_valid;
  logic [63:0] w_out_data;
  logic [4:0]  w_out_tag;

  pipelined_shifter #(.WIDTH(64), .PIPE_STAGES(2), .TAG_WIDTH(5)) u_dut64 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_amount(w_in_amount), .in_op(w_in_op), .in_tag(w_in_tag),
    .in_word(w_in_word),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_data(w_out_data), .out_tag(w_out_tag)
  );

  task automatic run64(input string name, input logic word, input logic [1:0] op,
                       input logic [63:0] d, input logic [5:0] a, input logic [63:0] exp);
    @(negedge clock);
    w_in_valid = 1'b1; w_in_word = word; w_in_op = op; w_in_data = d; w_in_amount = a; w_in_tag = 5'h11;
    @(negedge clock);
    w_in_valid = 1'b0;
    @(negedge clock);
    check({name, "_vld"}, 64'(w_out_valid), 64'd1);
    check({name, "_data"}, w_out_data, exp);
  endtask
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send one beat into an empty pipe and check it appears exactly two edges later.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] a, input logic [4:0] tg, input logic [31:0] exp);
    @(negedge clock);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = op; in_data = d; in_amount = a; in_tag = tg;
    @(negedge clock);
    in_valid = 1'b0; in_op = ~op; in_data = ~d; in_amount = ~a; in_tag = ~tg;
    check({name, "_lat"}, 64'(out_valid), 64'd0);
    @(negedge clock);
    check({name, "_vld"}, 64'(out_valid), 64'd1);
    check({name, "_data"}, 64'(out_data), 64'(exp));
    check({name, "_tag"}, 64'(out_tag), 64'(tg));
  endtask

  initial begin
    int tx;
    int rx;
    int seen;

    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_tag = 5'h1F;
    repeat (2) @(negedge clock);
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_no_beat", 64'(out_valid), 64'd0);

    run_op("sll31",  2'b00, 32'h0000_0001, 5'd31, 5'h1A, 32'h8000_0000);
    run_op("sra4",   2'b10, 32'h8000_0000, 5'd4,  5'h01, 32'hF800_0000);
    run_op("srl4",   2'b01, 32'h8000_0000, 5'd4,  5'h02, 32'h0800_0000);
    run_op("sll0",   2'b00, 32'hDEAD_BEEF, 5'd0,  5'h03, 32'hDEAD_BEEF);
    run_op("srl0",   2'b01, 32'hDEAD_BEEF, 5'd0,  5'h04, 32'hDEAD_BEEF);
    run_op("sra0",   2'b10, 32'hDEAD_BEEF, 5'd0,  5'h05, 32'hDEAD_BEEF);
    run_op("ror0",   2'b11, 32'hDEAD_BEEF, 5'd0,  5'h06, 32'hDEAD_BEEF);
    run_op("ror4",   2'b11, 32'h0000_00F1, 5'd4,  5'h07, 32'h1000_000F);
    run_op("ror31",  2'b11, 32'h0000_0001, 5'd31, 5'h08, 32'h0000_0002);
    run_op("sll8",   2'b00, 32'h1234_5678, 5'd8,  5'h09, 32'h3456_7800);
    run_op("ror16",  2'b11, 32'h1234_5678, 5'd16, 5'h0A, 32'h5678_1234);
    run_op("srl31",  2'b01, 32'hDEAD_BEEF, 5'd31, 5'h0B, 32'h0000_0001);
    run_op("sra31",  2'b10, 32'hDEAD_BEEF, 5'd31, 5'h0C, 32'hFFFF_FFFF);
    run_op("srapos", 2'b10, 32'h7000_0000, 5'd3,  5'h0D, 32'h0E00_0000);
    run_op("sra5",   2'b10, 32'h8000_00F0, 5'd5,  5'h0E, 32'hFC00_0007);
    run_op("sra9",   2'b10, 32'h8000_0000, 5'd9,  5'h0F, 32'hFFC0_0000);
    run_op("ror1",   2'b11, 32'h8000_0001, 5'd1,  5'h10, 32'hC000_0000);

    // Backpressure: consumer stalls for cycles 0..3, then drains.
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clock);
      out_ready = (cyc >= 4);
      in_valid = (tx < 5); in_op = 2'b00; in_amount = 5'd1;
      in_data = 32'(tx + 1); in_tag = 5'(tx + 1);
      #1;
      if (cyc < 2) check("bp_ready_hi", 64'(in_ready), 64'd1);
      if (cyc == 2 || cyc == 3) begin
        check("bp_ready_lo", 64'(in_ready), 64'd0);
        check("bp_hold_tag", 64'(out_tag), 64'd1);
        check("bp_hold_data", 64'(out_data), 64'd2);
      end
      if (out_valid && out_ready) begin
        check("bp_tag", 64'(out_tag), 64'(rx + 1));
        check("bp_data", 64'(out_data), 64'((rx + 1) * 2));
        check("bp_cycle", 64'(cyc), 64'(rx + 4));
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    check("bp_count", 64'(rx), 64'd5);

    // Reset with two beats held in the pipe.
    @(negedge clock);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_data = 32'h3; in_amount = 5'd2; in_tag = 5'h07;
    @(negedge clock);
    in_data = 32'h5; in_tag = 5'h08;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check("mid_full_vld", 64'(out_valid), 64'd1);
    check("mid_full_rdy", 64'(in_ready), 64'd0);
    check("mid_full_tag", 64'(out_tag), 64'h07);
    reset_n = 1'b0;
    #1;
    check("mid_rst_vld", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_tag", 64'(out_tag), 64'd0);
    in_valid = 1'b1; in_data = 32'h1234;
    repeat (2) @(negedge clock);
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check("mid_post_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    check("mid_no_stale", 64'(seen), 64'd0);
    run_op("post_rst", 2'b00, 32'h0000_0003, 5'd2, 5'h13, 32'h0000_000C);

`ifdef SHIFTER_WORD32_EN
    run64("w_sll",   1'b1, 2'b00, 64'h0000_0000_4000_0000, 6'd1, 64'hFFFF_FFFF_8000_0000);
    run64("d_sll",   1'b0, 2'b00, 64'h0000_0000_4000_0000, 6'd1, 64'h0000_0000_8000_0000);
    run64("w_sra",   1'b1, 2'b10, 64'h0000_0000_8000_0000, 6'd4, 64'hFFFF_FFFF_F800_0000);
    run64("w_ror",   1'b1, 2'b11, 64'hFFFF_0000_0000_0001, 6'd1, 64'hFFFF_FFFF_8000_0000);
    run64("w_amt5",  1'b1, 2'b00, 64'h0000_0000_0000_0001, 6'd33, 64'h0000_0000_0000_0002);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
Parametrised, pipelined multi-mode shifter. It is the next-generation replacement for the 32-bit two-direction combinational barrel shifter.
- Supports SLL, SRL, SRA and ROR at configurable width, with configurable pipeline register slices.
- Uses a valid/ready handshake and carries a tag through unchanged.
- Sits between the ALU issue stage and writeback so that 64-bit shifts meet timing.

Parameters:
- WIDTH, 32: datapath width in bits; power of two, 8..64. LOG2W = clog2(WIDTH).
- PIPE_STAGES, 2: number of register slices, range 1..LOG2W. Latency equals PIPE_STAGES cycles.
- TAG_WIDTH, 5: width of the sideband tag (e.g. destination register number).

Ports:
- clock, in, 1: sole clock; all state updates on the rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: shifter can accept a beat this cycle.
- in_data, in, WIDTH: operand.
- in_amount, in, LOG2W: shift/rotate amount.
- in_op, in, 2: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag, in, TAG_WIDTH: sideband; returned unchanged with the result.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, WIDTH: result.
- out_tag, out, TAG_WIDTH: tag of the result.

Behaviour:
- Reset: while reset_n is low, all slice valid bits, out_valid, out_data and out_tag are 0, asynchronously. in_ready is 1 on the first edge after reset_n rises.
- Datapath: LOG2W mux levels. Level j shifts by 2^j when in_amount[j] is 1, starting from j=0.
- Fill rules:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with in_data[WIDTH-1] of the original operand at every level.
  - ROR wraps the bits shifted out into the vacated top positions.
- Slice assignment: level j belongs to slice floor(j*PIPE_STAGES/LOG2W). Each slice ends in a register holding valid, partial data, remaining amount bits, op, sign bit and tag.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N+PIPE_STAGES-1.
  - Example: PIPE_STAGES=1 means the result is registered once, visible the cycle after acceptance.
- Handshake:
  - A beat transfers on the input when in_valid && in_ready.
  - A beat transfers on the output when out_valid && out_ready.
- Advance rule:
  - Last slice: adv[P-1] = valid[P-1] && out_ready.
  - Other slices: adv[k] = valid[k] && (!valid[k+1] || adv[k+1]).
  - in_ready = !valid[0] || adv[0]. This is combinational from out_ready; no skid buffer.
- Bubbles collapse: an empty slice is filled even while downstream slices are stalled.
- Stall: while out_valid && !out_ready, out_data and out_tag stay stable. No beat is dropped, duplicated or reordered. Capacity is PIPE_STAGES beats.
- Simultaneous events: with all slices full, output accepted and in_valid high in the same cycle, the pipeline shifts and the new beat is accepted, giving full throughput of 1 beat/cycle.
- Amount 0: out_data == in_data for every op.
- Reset mid-operation: all in-flight beats are discarded and no out_valid is produced for them. Inputs presented during reset are ignored.
- in_op and in_amount are sampled only at input acceptance. Later changes do not affect in-flight beats.

Optional Feature:
Macro SHIFTER_WORD32_EN.
- Defined (only legal with WIDTH=64): adds input port in_word (1 bit, travels with the beat).
  - When in_word=1, the operation uses in_data[31:0] and in_amount[4:0] only.
  - SRA fills from bit 31; ROR rotates within 32 bits.
  - The 32-bit result is sign-extended from bit 31 to 64 bits (MIPS64 SLL/SRL/SRA/ROTR semantics).
  - When in_word=0, behaviour is the full-width operation.
- Undefined: port absent; all operations are full-width.

Test Plan:
- SLL, WIDTH=32, PIPE_STAGES=2: in_data=0x00000001, amount=31 -> out_data=0x80000000, tag 0x1A echoed, out_valid exactly 2 edges after acceptance.
- SRA vs SRL: in_data=0x80000000, amount=4 -> SRA gives 0xF8000000, SRL gives 0x08000000. Also every op with amount=0 on 0xDEADBEEF returns 0xDEADBEEF.
- ROR: in_data=0x000000F1, amount=4 -> 0x1000000F. ROR amount=31 on 0x00000001 -> 0x00000002.
- Backpressure:
  - Stream tags 1..5 with out_ready held low 4 cycles: in_ready drops after 2 beats are held.
  - Then raise out_ready: tags emerge 1..5 in order, one per cycle, data stable while stalled.
- Reset mid-operation: assert reset_n=0 with 2 beats in flight -> out_valid=0 and out_data=0 immediately. After release, no stale beat appears and in_ready=1.
- SHIFTER_WORD32_EN, WIDTH=64:
  - in_word=1, SLL 0x0000000040000000 by 1 -> 0xFFFFFFFF80000000.
  - in_word=0, same inputs -> 0x0000000080000000.
